// File: rtl/sb_pkg.sv
// Shared constants for the register scoreboard: register-index width and
// register-file select encoding.
package sb_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned NUM_REGS  = 32;

    localparam logic FILE_INT = 1'b0;
    localparam logic FILE_FP  = 1'b1;

endpackage

// File: rtl/pending_bank.sv
// One 32-entry pending vector with set/clear ports and three combinational
// lookups that see a same-cycle clear as already applied.
module pending_bank
    import sb_pkg::*;
#(
    parameter bit ZERO_HARDWIRED = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      set_i,
    input  logic [REG_IDX_W-1:0]      set_idx_i,
    input  logic                      clr_i,
    input  logic [REG_IDX_W-1:0]      clr_idx_i,
    input  logic [2:0][REG_IDX_W-1:0] look_idx_i,
    output logic [2:0]                look_pend_o,
    output logic                      clr_hit_o,
    output logic                      any_o
);

    logic [NUM_REGS-1:0] pend_d, pend_q;

    // Clear first so a simultaneous set of the same entry wins.
    always_comb begin
        pend_d = pend_q;
        if (clr_i) begin
            pend_d[clr_idx_i] = 1'b0;
        end
        if (set_i) begin
            pend_d[set_idx_i] = 1'b1;
        end
        if (ZERO_HARDWIRED) begin
            pend_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        look_pend_o = '0;
        for (int k = 0; k < 3; k++) begin
            look_pend_o[k] = pend_q[look_idx_i[k]] &
                             ~(clr_i & (clr_idx_i == look_idx_i[k]));
        end
    end

    assign clr_hit_o = pend_q[clr_idx_i];
    assign any_o     = |pend_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard for long-latency writes; stalls ID on RAW/WAW hazards
// and when the outstanding limit is reached. SCOREBOARD_FLOAT_EN adds the FP file.
module reg_scoreboard
    import sb_pkg::*;
#(
    parameter int unsigned MAX_PENDING = 4,
    parameter int unsigned CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] rs1id,
    input  logic [REG_IDX_W-1:0] rs2id,
    input  logic [REG_IDX_W-1:0] rdid,
    input  logic [1:0]           float_read,
    input  logic                 float_rd,
    input  logic [1:0]           uses_rs,
    input  logic                 issue_valid,
    input  logic                 issue_long,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 wb_float,
    output logic                 stall,
    output logic                 busy,
    output logic [CNT_W-1:0]     pending_cnt,
    output logic                 sb_err
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_PENDING);

    logic sel_rs1, sel_rs2, sel_rd, sel_wb;
    logic [2:0][REG_IDX_W-1:0] look_idx;
    logic [2:0] int_look, fp_look, eff;
    logic int_hit, fp_hit, int_any, fp_any;
    logic wb_hit, set_fire, clr_fire;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic sb_err_d, sb_err_q;

    assign look_idx = {rs1id, rs2id, rdid};

    pending_bank #(
        .ZERO_HARDWIRED (1'b1)
    ) u_int_bank (
        .clk         (clk),
        .rst         (rst),
        .set_i       (set_fire & (sel_rd == FILE_INT)),
        .set_idx_i   (rdid),
        .clr_i       (wb_valid & (sel_wb == FILE_INT)),
        .clr_idx_i   (wb_rd),
        .look_idx_i  (look_idx),
        .look_pend_o (int_look),
        .clr_hit_o   (int_hit),
        .any_o       (int_any)
    );

`ifdef SCOREBOARD_FLOAT_EN
    assign sel_rs1 = float_read[1];
    assign sel_rs2 = float_read[0];
    assign sel_rd  = float_rd;
    assign sel_wb  = wb_float;

    pending_bank #(
        .ZERO_HARDWIRED (1'b0)
    ) u_fp_bank (
        .clk         (clk),
        .rst         (rst),
        .set_i       (set_fire & (sel_rd == FILE_FP)),
        .set_idx_i   (rdid),
        .clr_i       (wb_valid & (sel_wb == FILE_FP)),
        .clr_idx_i   (wb_rd),
        .look_idx_i  (look_idx),
        .look_pend_o (fp_look),
        .clr_hit_o   (fp_hit),
        .any_o       (fp_any)
    );
`else
    // Float selects are kept on the port list but every access is integer.
    logic unused_float;
    assign unused_float = ^{float_read, float_rd, wb_float};
    assign sel_rs1 = FILE_INT;
    assign sel_rs2 = FILE_INT;
    assign sel_rd  = FILE_INT;
    assign sel_wb  = FILE_INT;
    assign fp_look = '0;
    assign fp_hit  = 1'b0;
    assign fp_any  = 1'b0;
`endif

    always_comb begin
        eff[2] = (sel_rs1 == FILE_FP) ? fp_look[2] : int_look[2];
        eff[1] = (sel_rs2 == FILE_FP) ? fp_look[1] : int_look[1];
        eff[0] = (sel_rd  == FILE_FP) ? fp_look[0] : int_look[0];
    end

    assign stall = (uses_rs[1] & eff[2]) |
                   (uses_rs[0] & eff[1]) |
                   (issue_long & eff[0]) |
                   (issue_long & (cnt_q == MaxCnt) & ~wb_valid);

    assign wb_hit   = (sel_wb == FILE_FP) ? fp_hit : int_hit;
    assign clr_fire = wb_valid & wb_hit;
    assign set_fire = issue_valid & issue_long & ~stall &
                      ~((rdid == '0) & (sel_rd == FILE_INT));

    always_comb begin
        cnt_d = cnt_q;
        case ({set_fire, clr_fire})
            2'b10: if (cnt_q != MaxCnt) cnt_d = cnt_q + 1'b1;
            2'b01: if (cnt_q != '0)     cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        sb_err_d = sb_err_q | (wb_valid & ~wb_hit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            sb_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign pending_cnt = cnt_q;
    assign sb_err      = sb_err_q;
    assign busy        = int_any | fp_any;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus random
// traffic against a set-of-pending-registers reference model.
module tb_reg_scoreboard;

    localparam int MAXP  = 4;
    localparam int CNT_W = $clog2(MAXP + 1);
`ifdef SCOREBOARD_FLOAT_EN
    localparam bit FLOAT_EN = 1'b1;
`else
    localparam bit FLOAT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs1id, rs2id, rdid, wb_rd;
    logic [1:0] float_read, uses_rs;
    logic float_rd, issue_valid, issue_long, wb_valid, wb_float;
    logic stall, busy, sb_err;
    logic [CNT_W-1:0] pending_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: which registers await a result, plus counters.
    bit int_p[32];
    bit fp_p[32];
    int m_cnt;
    bit m_err;

    reg_scoreboard #(
        .MAX_PENDING (MAXP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rs1id       (rs1id),
        .rs2id       (rs2id),
        .rdid        (rdid),
        .float_read  (float_read),
        .float_rd    (float_rd),
        .uses_rs     (uses_rs),
        .issue_valid (issue_valid),
        .issue_long  (issue_long),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_float    (wb_float),
        .stall       (stall),
        .busy        (busy),
        .pending_cnt (pending_cnt),
        .sb_err      (sb_err)
    );

    always #5 clk = ~clk;

    function automatic bit m_pend(bit f, logic [4:0] idx);
        if (f && FLOAT_EN) return fp_p[idx];
        return int_p[idx];
    endfunction

    function automatic bit m_eff(bit f, logic [4:0] idx);
        bit same_file;
        same_file = ((f && FLOAT_EN) == (wb_float && FLOAT_EN));
        return m_pend(f, idx) && !(wb_valid && same_file && wb_rd == idx);
    endfunction

    function automatic bit m_stall();
        return (uses_rs[1] && m_eff(float_read[1], rs1id)) ||
               (uses_rs[0] && m_eff(float_read[0], rs2id)) ||
               (issue_long && m_eff(float_rd, rdid)) ||
               (issue_long && m_cnt == MAXP && !wb_valid);
    endfunction

    function automatic bit m_busy();
        for (int i = 0; i < 32; i++) if (int_p[i] || fp_p[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            int_p[i] = 1'b0;
            fp_p[i]  = 1'b0;
        end
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    task automatic idle();
        rs1id = 0; rs2id = 0; rdid = 0; wb_rd = 0;
        float_read = 0; uses_rs = 0; float_rd = 0;
        issue_valid = 0; issue_long = 0; wb_valid = 0; wb_float = 0;
    endtask

    // Advance one clock, applying the issue/writeback rules to the model.
    task automatic clk_step();
        bit st, set_f, clr_f, fp_rd, fp_wb;
        st    = m_stall();
        fp_rd = float_rd && FLOAT_EN;
        fp_wb = wb_float && FLOAT_EN;
        set_f = issue_valid && issue_long && !st && !(rdid == 0 && !fp_rd);
        clr_f = wb_valid && m_pend(wb_float, wb_rd);
        if (wb_valid && !clr_f) m_err = 1'b1;
        @(posedge clk);
        if (clr_f) begin
            if (fp_wb) fp_p[wb_rd] = 1'b0; else int_p[wb_rd] = 1'b0;
        end
        if (set_f) begin
            if (fp_rd) fp_p[rdid] = 1'b1; else int_p[rdid] = 1'b1;
        end
        if (set_f && !clr_f && m_cnt < MAXP) m_cnt++;
        if (clr_f && !set_f && m_cnt > 0) m_cnt--;
        #1;
    endtask

    task automatic issue(logic [4:0] rd, bit f);
        idle();
        issue_valid = 1; issue_long = 1; rdid = rd; float_rd = f;
    endtask

    task automatic wb(logic [4:0] rd, bit f);
        idle();
        wb_valid = 1; wb_rd = rd; wb_float = f;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        m_reset();
        #3;
        checks++;
        if (pending_cnt !== '0) begin
            errors++; $display("FAIL reset_cnt: got %0d want 0", pending_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", sb_err); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_raw_load();
        issue(5, 0);
        clk_step();
        checks++;
        if (pending_cnt !== CNT_W'(m_cnt)) begin
            errors++; $display("FAIL raw_cnt_set: got %0d want %0d", pending_cnt, m_cnt);
        end
        idle(); rs1id = 5; uses_rs = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (stall !== m_stall()) begin
                errors++; $display("FAIL raw_stall_hold: got %b want %b", stall, m_stall());
            end
            clk_step();
        end
        wb_valid = 1; wb_rd = 5;
        #2;
        checks++;
        if (stall !== m_stall()) begin
            errors++; $display("FAIL raw_wb_bypass: got %b want %b", stall, m_stall());
        end
        clk_step();
        checks++;
        if (pending_cnt !== CNT_W'(m_cnt) || busy !== m_busy()) begin
            errors++; $display("FAIL raw_cnt_clr: got %0d/%b want %0d/%b",
                               pending_cnt, busy, m_cnt, m_busy());
        end
    endtask

    task automatic test_x0();
        issue(0, 0);
        #2;
        checks++;
        if (stall !== m_stall()) begin errors++; $display("FAIL x0_stall: got %b want %b", stall, m_stall()); end
        clk_step();
        checks++;
        if (pending_cnt !== CNT_W'(m_cnt) || busy !== m_busy()) begin
            errors++; $display("FAIL x0_noset: got %0d/%b want %0d/%b",
                               pending_cnt, busy, m_cnt, m_busy());
        end
    endtask

    task automatic test_fp_file();
        issue(3, 1);
        clk_step();
        idle(); rs2id = 3; uses_rs = 2'b01; float_read = 2'b00;
        #2;
        checks++;
        if (stall !== m_stall()) begin errors++; $display("FAIL fp_int_read: got %b want %b", stall, m_stall()); end
        float_read = 2'b01;
        #2;
        checks++;
        if (stall !== m_stall()) begin errors++; $display("FAIL fp_fp_read: got %b want %b", stall, m_stall()); end
        wb(3, 1);
        clk_step();
        checks++;
        if (pending_cnt !== CNT_W'(m_cnt) || sb_err !== m_err) begin
            errors++; $display("FAIL fp_drain: got %0d/%b want %0d/%b", pending_cnt, sb_err, m_cnt, m_err);
        end
    endtask

    task automatic test_full();
        for (int r = 1; r <= 4; r++) begin
            issue(5'(r), 0);
            clk_step();
        end
        checks++;
        if (pending_cnt !== CNT_W'(m_cnt)) begin
            errors++; $display("FAIL full_cnt: got %0d want %0d", pending_cnt, m_cnt);
        end
        issue(6, 0);
        #2;
        checks++;
        if (stall !== m_stall()) begin errors++; $display("FAIL full_stall: got %b want %b", stall, m_stall()); end
        clk_step();
        wb_valid = 1; wb_rd = 2;
        #2;
        checks++;
        if (stall !== m_stall()) begin errors++; $display("FAIL full_wb_unblock: got %b want %b", stall, m_stall()); end
        clk_step();
        checks++;
        if (pending_cnt !== CNT_W'(m_cnt)) begin
            errors++; $display("FAIL full_swap_cnt: got %0d want %0d", pending_cnt, m_cnt);
        end
        for (int r = 1; r <= 6; r++) begin
            if (int_p[r]) begin
                wb(5'(r), 0);
                clk_step();
            end
        end
        idle();
    endtask

    task automatic test_set_clear_same();
        issue(7, 0);
        clk_step();
        issue(7, 0); wb_valid = 1; wb_rd = 7;
        #2;
        checks++;
        if (stall !== m_stall()) begin errors++; $display("FAIL same_stall: got %b want %b", stall, m_stall()); end
        clk_step();
        checks++;
        if (pending_cnt !== CNT_W'(m_cnt) || busy !== m_busy()) begin
            errors++; $display("FAIL same_cnt: got %0d/%b want %0d/%b", pending_cnt, busy, m_cnt, m_busy());
        end
        idle(); rs1id = 7; uses_rs = 2'b10;
        #2;
        checks++;
        if (stall !== m_stall()) begin errors++; $display("FAIL same_still_pend: got %b want %b", stall, m_stall()); end
        wb(7, 0);
        clk_step();
        idle();
    endtask

    task automatic test_err_async();
        wb(9, 0);
        clk_step();
        idle();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sb_err !== m_err) begin errors++; $display("FAIL err_sticky: got %b want %b", sb_err, m_err); end
            clk_step();
        end
        issue(8, 0);
        clk_step();
        idle();
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        checks++;
        if (pending_cnt !== '0 || busy !== 1'b0 || sb_err !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL async_reset: got cnt=%0d busy=%b err=%b stall=%b want all 0",
                               pending_cnt, busy, sb_err, stall);
        end
        @(negedge clk);
        rst = 1'b0;
        wb(8, 0);
        clk_step();
        idle();
        checks++;
        if (sb_err !== m_err) begin errors++; $display("FAIL dropped_wb_err: got %b want %b", sb_err, m_err); end
        rst = 1'b1;
        m_reset();
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int pend_q[$];
        for (int cyc = 0; cyc < 400; cyc++) begin
            rs1id = 5'($urandom); rs2id = 5'($urandom); rdid = 5'($urandom_range(0, 15));
            float_read = 2'($urandom); float_rd = 1'($urandom); uses_rs = 2'($urandom);
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_long = $urandom_range(0, 1);
            wb_valid = ($urandom_range(0, 2) == 0);
            pend_q.delete();
            for (int i = 0; i < 32; i++) begin
                if (int_p[i]) pend_q.push_back(i);
                if (fp_p[i] && FLOAT_EN) pend_q.push_back(32 + i);
            end
            if (pend_q.size() > 0 && $urandom_range(0, 9) != 0) begin
                int pick;
                pick = pend_q[$urandom_range(0, pend_q.size() - 1)];
                wb_rd = 5'(pick % 32);
                wb_float = (pick >= 32);
            end else begin
                wb_rd = 5'($urandom);
                wb_float = 1'($urandom);
            end
            #2;
            checks++;
            if (stall !== m_stall()) begin
                errors++; $display("FAIL rnd_stall cyc %0d: got %b want %b", cyc, stall, m_stall());
            end
            clk_step();
            checks++;
            if (pending_cnt !== CNT_W'(m_cnt) || busy !== m_busy() || sb_err !== m_err) begin
                errors++; $display("FAIL rnd_state cyc %0d: got %0d/%b/%b want %0d/%b/%b", cyc,
                                   pending_cnt, busy, sb_err, m_cnt, m_busy(), m_err);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b0;
        m_reset();
        #1;
        test_reset();
        test_raw_load();
        test_x0();
        test_fp_file();
        test_full();
        test_set_clear_same();
        test_err_async();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
